// File: rtl/incr_stream_pkg.sv
// Shared constants and helpers for the +1 incrementer stream. The encoder and the
// decoder both import this package so the increment and the frame check stay matched.
package incr_stream_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_INC    = 1;

  function automatic logic [DEF_DATA_W-1:0] dec_word(input logic [DEF_DATA_W-1:0] data);
    return data - DEF_DATA_W'(DEF_INC);
  endfunction

  // A word is well-formed when valid is high exactly when the encoded data is non-zero.
  function automatic logic frame_ok(input logic valid, input logic [DEF_DATA_W-1:0] data);
    return valid == (data != '0);
  endfunction

endpackage

// File: rtl/stream_sync_fifo.sv
// Show-ahead synchronous FIFO with extra-MSB pointers; a push while full is
// accepted only when a pop frees a slot on the same edge.
module stream_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wptr_q, rptr_q;
  logic              do_push, do_pop;

  always_comb begin
    empty     = (wptr_q == rptr_q);
    full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    level     = wptr_q - rptr_q;
    head_data = mem_q[rptr_q[AW-1:0]];
    do_pop    = pop && !empty;
    do_push   = push && (!full || do_pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/incr_stream_decoder.sv
// Receive side of the +1 incrementer: capture, frame check, subtract the increment,
// buffer in a show-ahead FIFO and keep drop / protocol-error statistics.
module incr_stream_decoder
  import incr_stream_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int INC    = DEF_INC,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      enc_data_in,
  input  logic                   enc_valid_in,
  output logic [DATA_W-1:0]      dec_data_out,
  output logic                   dec_valid_out,
  input  logic                   dec_ready_in,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [7:0]             drop_count,
  output logic                   overflow_sticky,
  output logic                   protocol_err,
  input  logic                   clear_stats
);

  logic              cap_valid_q, cap_valid_d;
  logic [DATA_W-1:0] cap_data_q, cap_data_d;
  logic [7:0]        drop_count_q, drop_count_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;
  logic              frame_bad, pop, drop;
  logic              fifo_empty, fifo_full;
  logic [DATA_W-1:0] head_data;

  always_comb begin
    frame_bad   = !frame_ok(enc_valid_in, enc_data_in);
    cap_valid_d = enc_valid_in && (enc_data_in != '0);
    cap_data_d  = enc_data_in - DATA_W'(INC);
  end

  always_comb begin
    pop          = !fifo_empty && dec_ready_in;
    drop         = cap_valid_q && fifo_full && !pop;
    drop_count_d = drop_count_q;
    ovf_d        = ovf_q;
    err_d        = err_q;
    // Clear wins over any drop or error that lands on the same edge.
    if (clear_stats) begin
      drop_count_d = '0;
      ovf_d        = 1'b0;
      err_d        = 1'b0;
    end else begin
      if (drop) begin
        if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
        ovf_d = 1'b1;
      end
      if (frame_bad) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_valid_q  <= 1'b0;
      cap_data_q   <= '0;
      drop_count_q <= '0;
      ovf_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      cap_valid_q  <= cap_valid_d;
      cap_data_q   <= cap_data_d;
      drop_count_q <= drop_count_d;
      ovf_q        <= ovf_d;
      err_q        <= err_d;
    end
  end

  stream_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cap_valid_q),
    .push_data (cap_data_q),
    .pop       (pop),
    .head_data (head_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (fifo_level)
  );

  always_comb begin
    dec_valid_out   = !fifo_empty;
    dec_data_out    = fifo_empty ? '0 : head_data;
    drop_count      = drop_count_q;
    overflow_sticky = ovf_q;
    protocol_err    = err_q;
  end

endmodule

// File: tb/tb_incr_stream_decoder.sv
// Directed bench for incr_stream_decoder with a queue-based scoreboard of expected words.
module tb_incr_stream_decoder;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [DATA_W-1:0] enc_data_in = '0;
  logic              enc_valid_in = 1'b0;
  logic [DATA_W-1:0] dec_data_out;
  logic              dec_valid_out;
  logic              dec_ready_in = 1'b0;
  logic [2:0]        fifo_level;
  logic [7:0]        drop_count;
  logic              overflow_sticky;
  logic              protocol_err;
  logic              clear_stats = 1'b0;

  int checks = 0;
  int passed = 0;

  logic [7:0] exp_q[$];
  logic       m_cap_v;
  logic [7:0] m_cap_d;
  int         m_drop;
  logic       m_ovf, m_err;
  int         max_level;
  int         vld_cycles;

  incr_stream_decoder #(.DATA_W(DATA_W), .INC(1), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .enc_data_in     (enc_data_in),
    .enc_valid_in    (enc_valid_in),
    .dec_data_out    (dec_data_out),
    .dec_valid_out   (dec_valid_out),
    .dec_ready_in    (dec_ready_in),
    .fifo_level      (fifo_level),
    .drop_count      (drop_count),
    .overflow_sticky (overflow_sticky),
    .protocol_err    (protocol_err),
    .clear_stats     (clear_stats)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_cap_v = 1'b0;
    m_cap_d = '0;
    m_drop  = 0;
    m_ovf   = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_valid"}, dec_valid_out, exp_q.size() != 0);
    check({tag, "_data"},  dec_data_out, exp_q.size() != 0 ? exp_q[0] : 8'h00);
    check({tag, "_level"}, fifo_level, exp_q.size());
    check({tag, "_drops"}, drop_count, m_drop);
    check({tag, "_ovf"},   overflow_sticky, m_ovf);
    check({tag, "_perr"},  protocol_err, m_err);
  endtask

  // Predict the edge from the inputs currently driven, then let the edge happen and compare.
  task automatic step(input string tag);
    bit do_pop, is_full, bad;
    do_pop  = dec_ready_in && (exp_q.size() > 0);
    is_full = (exp_q.size() == DEPTH);
    bad     = enc_valid_in != (enc_data_in != 8'h00);
    if (clear_stats) begin
      m_drop = 0;
      m_ovf  = 1'b0;
      m_err  = 1'b0;
    end else begin
      if (m_cap_v && is_full && !do_pop) begin
        if (m_drop < 255) m_drop++;
        m_ovf = 1'b1;
      end
      if (bad) m_err = 1'b1;
    end
    if (do_pop) void'(exp_q.pop_front());
    if (m_cap_v && !(is_full && !do_pop)) exp_q.push_back(m_cap_d);
    m_cap_v = enc_valid_in && (enc_data_in != 8'h00);
    m_cap_d = enc_data_in - 8'd1;
    @(posedge clk);
    #1;
    check_outputs(tag);
    if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
    if (dec_valid_out) vld_cycles++;
  endtask

  task automatic drive(input string tag, input logic [7:0] d);
    enc_valid_in = (d != 8'h00);
    enc_data_in  = d;
    step(tag);
  endtask

  task automatic idle(input string tag, input int n);
    enc_valid_in = 1'b0;
    enc_data_in  = 8'h00;
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    model_reset();
    #12;
    check_outputs("reset");
    reset = 1'b1;

    // Test 1: basic decode and 2-edge latency
    dec_ready_in = 1'b1;
    max_level    = 0;
    vld_cycles   = 0;
    drive("t1", 8'h01);
    check("t1_lat_edge1", dec_valid_out, 1'b0);
    drive("t1", 8'h02);
    check("t1_first_word", dec_data_out, 8'h00);
    drive("t1", 8'h80);
    check("t1_second_word", dec_data_out, 8'h01);
    idle("t1", 1);
    check("t1_third_word", dec_data_out, 8'h7F);
    idle("t1", 2);
    check("t1_valid_cycles", vld_cycles, 3);
    check("t1_max_level_le1", max_level <= 1, 1'b1);

    // Test 2: fill with ready low, two drops, ordered drain
    dec_ready_in = 1'b0;
    for (int i = 0; i < 6; i++) drive("t2", 8'h11 + 8'(i));
    idle("t2", 1);
    check("t2_level_full", fifo_level, 3'd4);
    check("t2_drop_count", drop_count, 8'd2);
    check("t2_overflow", overflow_sticky, 1'b1);
    dec_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t2_order", dec_data_out, 8'h10 + 8'(i));
      idle("t2", 1);
    end
    check("t2_drained", dec_valid_out, 1'b0);

    // Test 3: push and pop on the same edge while full
    dec_ready_in = 1'b0;
    clear_stats  = 1'b1;
    idle("t3", 1);
    clear_stats  = 1'b0;
    for (int i = 0; i < 4; i++) drive("t3", 8'h31 + 8'(i));
    idle("t3", 1);
    check("t3_full_before", fifo_level, 3'd4);
    drive("t3", 8'h21);
    dec_ready_in = 1'b1;
    idle("t3", 1);
    check("t3_level_held", fifo_level, 3'd4);
    check("t3_no_drop", drop_count, 8'd0);
    for (int i = 0; i < 3; i++) begin
      check("t3_order_old", dec_data_out, 8'h31 + 8'(i));
      idle("t3", 1);
    end
    check("t3_new_last", dec_data_out, 8'h20);
    idle("t3", 1);

    // Test 5: drop counter saturation
    dec_ready_in = 1'b0;
    for (int i = 0; i < 304; i++) drive("t5", 8'((i % 255) + 1));
    idle("t5", 1);
    check("t5_saturated", drop_count, 8'd255);
    check("t5_overflow", overflow_sticky, 1'b1);
    dec_ready_in = 1'b1;
    idle("t5", 4);

    // Test 4: protocol errors, then clear_stats
    enc_valid_in = 1'b1; enc_data_in = 8'h00; step("t4");
    enc_valid_in = 1'b0; enc_data_in = 8'h05; step("t4");
    idle("t4", 2);
    check("t4_perr_set", protocol_err, 1'b1);
    check("t4_nothing_stored", fifo_level, 3'd0);
    clear_stats = 1'b1;
    idle("t4", 1);
    clear_stats = 1'b0;
    check("t4_clr_perr", protocol_err, 1'b0);
    check("t4_clr_drops", drop_count, 8'd0);
    check("t4_clr_ovf", overflow_sticky, 1'b0);
    enc_valid_in = 1'b1; enc_data_in = 8'h00; clear_stats = 1'b1;
    step("t4_prio");
    clear_stats = 1'b0;
    idle("t4_prio", 1);
    check("t4_clear_priority", protocol_err, 1'b0);

    // Test 6: asynchronous reset with three words buffered and one in flight
    dec_ready_in = 1'b0;
    drive("t6", 8'h41);
    drive("t6", 8'h42);
    drive("t6", 8'h43);
    idle("t6", 1);
    check("t6_three_buffered", fifo_level, 3'd3);
    enc_valid_in = 1'b1;
    enc_data_in  = 8'h44;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs("t6_async");
    enc_valid_in = 1'b0;
    enc_data_in  = 8'h00;
    #10;
    reset = 1'b1;
    dec_ready_in = 1'b1;
    drive("t6_post", 8'h51);
    check("t6_post_lat1", dec_valid_out, 1'b0);
    idle("t6_post", 1);
    check("t6_post_word", dec_data_out, 8'h50);
    check("t6_post_valid", dec_valid_out, 1'b1);
    idle("t6_post", 2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/incr_stream_decoder.md
Name: incr_stream_decoder

Overview:
- Receive-side counterpart of the team's +1 incrementer stage. That stage emits `data + 1` with `valid = (data + 1 != 0)` and has no backpressure.
- This block samples that stream every clock, checks valid/data consistency and subtracts the increment to recover the original word.
- Recovered words are buffered in a small FIFO and presented on a ready/valid output to a downstream consumer.
- Drops and protocol errors are counted and flagged for status readout.

Parameters:
- DATA_W, 8, word width of input and output data.
- INC, 1, increment applied by the encoder; subtracted here modulo 2^DATA_W.
- DEPTH, 4, FIFO depth in words; power of two, minimum 2.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- enc_data_in  input  DATA_W  encoded word from the incrementer.
- enc_valid_in  input  1  encoder valid; no backpressure available.
- dec_data_out  output  DATA_W  recovered word at FIFO head.
- dec_valid_out  output  1  FIFO non-empty.
- dec_ready_in  input  1  consumer accepts when valid and ready are both high at an edge.
- fifo_level  output  $clog2(DEPTH)+1  words currently held.
- drop_count  output  8  words lost to FIFO full; saturates at 255.
- overflow_sticky  output  1  set on any drop.
- protocol_err  output  1  sticky; set on a valid/data mismatch.
- clear_stats  input  1  synchronous clear of drop_count, overflow_sticky and protocol_err.

Behaviour:
- Reset (reset = 0, asynchronous):
  - all outputs 0; FIFO empty; capture stage empty.
  - Reset mid-operation discards all buffered and in-flight words immediately.
- Stage 0, capture register, every edge:
  - `cap_valid <= enc_valid_in & (enc_data_in != 0)`
  - `cap_data <= enc_data_in - INC`, truncated to DATA_W (wraps: 0x00 - 1 = 0xFF).
- Consistency check:
  - A mismatch is `enc_valid_in != (enc_data_in != 0)`.
  - On a mismatch the word is not captured, and protocol_err is set on the next edge.
- Stage 1, FIFO write:
  - At the edge after capture, if cap_valid is high the word is pushed.
  - If the FIFO is full and no pop occurs that edge, the word is dropped: drop_count increments (saturating) and overflow_sticky sets.
- Simultaneous push and pop when full: the pop frees a slot, the push is accepted, and fifo_level is unchanged.
- Simultaneous push and pop at other levels: fifo_level is unchanged.
- Output is show-ahead:
  - dec_data_out equals the head word whenever dec_valid_out = 1.
  - dec_data_out holds its value while dec_valid_out = 1 and dec_ready_in = 0.
- Latency: a word present on enc_* before edge N is visible on dec_data_out/dec_valid_out after edge N+1. There is no empty-FIFO bypass; latency is fixed at 2 edges.
- Throughput: one word per clock sustained when dec_ready_in stays high.
- Pointers: read/write pointers are log2(DEPTH)+1 bits and wrap naturally. Full is MSBs differing with LSBs equal; empty is pointers equal.
- clear_stats:
  - Takes effect at the edge where it is sampled high.
  - It has priority over a same-edge drop or error: the result is 0 and the event is not counted.
  - It does not touch FIFO contents.
- Value range: an encoder input of 0xFF produces 0x00, which is invalid. The decoder therefore never outputs 0xFF for INC = 1; this is not an error condition.

Decomposition:
- Package incr_stream_pkg holds:
  - the DATA_W default and the INC constant.
  - function `dec_word(logic [DATA_W-1:0])` returning the value minus INC.
  - function `frame_ok(valid, data)` for the consistency check.
- The encoder-side block imports the same package so increment and check logic stay matched.
- One sub-module: stream_sync_fifo.
  - Parameters DATA_W and DEPTH.
  - Ports push, push_data, pop, head_data, empty, full, level.
  - Same clk/reset convention.
- The capture register, consistency check and statistics counters stay in the top level.

Test Plan:
1. Reset release, dec_ready_in = 1, drive encoded 0x01, 0x02, 0x80 on consecutive cycles → dec_data_out shows 0x00, 0x01, 0x7F. Each appears 2 edges after its input; dec_valid_out is high 3 cycles; fifo_level never exceeds 1.
2. dec_ready_in = 0, stream encoded 0x11..0x16 (6 words), DEPTH = 4 → fifo_level reaches 4, drop_count = 2, overflow_sticky = 1. After raising ready, the outputs are 0x10..0x13 in order.
3. FIFO full and dec_ready_in = 1 on the same edge as a new push of 0x21 → fifo_level stays 4, drop_count is unchanged, and 0x20 eventually appears after the older words.
4. Drive enc_valid_in = 1 with enc_data_in = 0x00, then enc_valid_in = 0 with 0x05 → protocol_err = 1, no word enters the FIFO. Then assert clear_stats for one cycle → protocol_err, drop_count and overflow_sticky all return to 0.
5. Force 300 drops with ready held low → drop_count saturates at 255.
6. Assert reset asynchronously mid-burst with 3 words buffered → outputs go to 0 without a clock edge. After release the FIFO is empty and the next input word emerges with the normal 2-edge latency.
